// File: rtl/exfifo_pkt_ctrl.sv
// ---------------------------------------------------------------------------
// exfifo_pkt_ctrl
//
// Packet sequencer between the host exchange FIFOs and the control CPU.
// A fixed-size command packet is popped from the inbound (show-ahead) FIFO
// into a local command buffer. The CPU reads it through a registered,
// word-addressed port and acknowledges it. The CPU then fills a local
// response buffer and requests transmission. The response packet is then
// streamed into the outbound FIFO. Only one packet is ever in flight.
//
// Ports
//   clk, reset           single clock, synchronous active-high reset
//   exfifo_if_d          inbound FIFO data (valid while rdempty=0)
//   exfifo_if_rdempty    inbound FIFO empty
//   exfifo_if_rd         inbound pop strobe (combinational)
//   exfifo_of_d          outbound FIFO data (combinational from rsp buffer)
//   exfifo_of_wrfull     outbound FIFO full
//   exfifo_of_wr         outbound write strobe (combinational)
//   exfifo_rst           CPU flush request, level sensitive
//   cmd_rdy              complete command packet held in buffer
//   cmd_addr / cmd_data  command buffer read port, 1-cycle latency
//   cmd_ack              pulse: command consumed
//   rsp_we/addr/wdata    response buffer write port (ignored during TX)
//   rsp_send             pulse: transmit the response packet
//   busy                 sequencer not idle
//   pkt_cnt              completed response packets, wraps
// ---------------------------------------------------------------------------
module exfifo_pkt_ctrl #(
  parameter int PKT_WORDS = 16,
  parameter int DW        = 32,
  localparam int AW       = $clog2(PKT_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] exfifo_if_d,
  input  logic          exfifo_if_rdempty,
  output logic          exfifo_if_rd,
  output logic [DW-1:0] exfifo_of_d,
  input  logic          exfifo_of_wrfull,
  output logic          exfifo_of_wr,
  input  logic          exfifo_rst,
  output logic          cmd_rdy,
  input  logic [AW-1:0] cmd_addr,
  output logic [DW-1:0] cmd_data,
  input  logic          cmd_ack,
  input  logic          rsp_we,
  input  logic [AW-1:0] rsp_addr,
  input  logic [DW-1:0] rsp_wdata,
  input  logic          rsp_send,
  output logic          busy,
  output logic [15:0]   pkt_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RX       = 3'd1,
    ST_CMD_WAIT = 3'd2,
    ST_RSP_WAIT = 3'd3,
    ST_TX       = 3'd4
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(PKT_WORDS - 1);
  localparam logic [AW-1:0] IDX_ZERO = AW'(0);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);

  // Sequencer state and registered outputs
  state_t        state_q,    state_d;
  logic [AW-1:0] rx_idx_q,   rx_idx_d;
  logic [AW-1:0] tx_idx_q,   tx_idx_d;
  logic          cmd_rdy_q,  cmd_rdy_d;
  logic          busy_q,     busy_d;
  logic [15:0]   pkt_cnt_q,  pkt_cnt_d;
  logic [DW-1:0] cmd_data_q, cmd_data_d;

  // Packet buffers; deliberately not reset (plain storage)
  logic [DW-1:0] rx_buf_q  [PKT_WORDS];
  logic [DW-1:0] rsp_buf_q [PKT_WORDS];

  // Qualified FIFO handshakes and response-buffer write enable
  logic pop;
  logic push;
  logic rsp_wr_en;

  // FIFO strobes: a flush (or reset) forces both strobes low in the same cycle
  always_comb begin
    pop       = 1'b0;
    push      = 1'b0;
    rsp_wr_en = rsp_we && (state_q != ST_TX);
    if (reset || exfifo_rst) begin
      pop  = 1'b0;
      push = 1'b0;
    end else begin
      pop  = (state_q == ST_RX) && !exfifo_if_rdempty;
      push = (state_q == ST_TX) && !exfifo_of_wrfull;
    end
  end

  // Next-state and next-output computation
  always_comb begin
    state_d    = state_q;
    rx_idx_d   = rx_idx_q;
    tx_idx_d   = tx_idx_q;
    pkt_cnt_d  = pkt_cnt_q;
    cmd_data_d = rx_buf_q[cmd_addr];

    if (exfifo_rst) begin
      // Flush abandons whatever is in progress; counters and buffers survive
      state_d  = ST_IDLE;
      rx_idx_d = IDX_ZERO;
      tx_idx_d = IDX_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rx_idx_d = IDX_ZERO;
          if (!exfifo_if_rdempty) begin
            state_d = ST_RX;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_RX: begin
          if (pop) begin
            rx_idx_d = rx_idx_q + IDX_ONE;
            if (rx_idx_q == LAST_IDX) begin
              state_d = ST_CMD_WAIT;
            end else begin
              state_d = ST_RX;
            end
          end else begin
            state_d = ST_RX;
          end
        end

        ST_CMD_WAIT: begin
          // A rsp_send arriving together with cmd_ack is intentionally dropped
          if (cmd_ack) begin
            state_d = ST_RSP_WAIT;
          end else begin
            state_d = ST_CMD_WAIT;
          end
        end

        ST_RSP_WAIT: begin
          if (rsp_send) begin
            state_d  = ST_TX;
            tx_idx_d = IDX_ZERO;
          end else begin
            state_d = ST_RSP_WAIT;
          end
        end

        ST_TX: begin
          if (push) begin
            tx_idx_d = tx_idx_q + IDX_ONE;
            if (tx_idx_q == LAST_IDX) begin
              state_d   = ST_IDLE;
              pkt_cnt_d = pkt_cnt_q + 16'd1;
            end else begin
              state_d = ST_TX;
            end
          end else begin
            state_d = ST_TX;
          end
        end

        default: begin
          state_d  = ST_IDLE;
          rx_idx_d = IDX_ZERO;
          tx_idx_d = IDX_ZERO;
        end
      endcase
    end

    // Status flags are registered copies of the next state
    cmd_rdy_d = (state_d == ST_CMD_WAIT);
    busy_d    = (state_d != ST_IDLE);
  end

  // Sequencer registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rx_idx_q   <= IDX_ZERO;
      tx_idx_q   <= IDX_ZERO;
      cmd_rdy_q  <= 1'b0;
      busy_q     <= 1'b0;
      pkt_cnt_q  <= 16'd0;
      cmd_data_q <= {DW{1'b0}};
    end else begin
      state_q    <= state_d;
      rx_idx_q   <= rx_idx_d;
      tx_idx_q   <= tx_idx_d;
      cmd_rdy_q  <= cmd_rdy_d;
      busy_q     <= busy_d;
      pkt_cnt_q  <= pkt_cnt_d;
      cmd_data_q <= cmd_data_d;
    end
  end

  // Command buffer fill from the inbound FIFO
  always_ff @(posedge clk) begin
    if (pop) begin
      rx_buf_q[rx_idx_q] <= exfifo_if_d;
    end
  end

  // Response buffer CPU writes; frozen while the packet is transmitted
  always_ff @(posedge clk) begin
    if (rsp_wr_en) begin
      rsp_buf_q[rsp_addr] <= rsp_wdata;
    end
  end

  assign exfifo_if_rd = pop;
  assign exfifo_of_wr = push;
  assign exfifo_of_d  = rsp_buf_q[tx_idx_q];
  assign cmd_rdy      = cmd_rdy_q;
  assign busy         = busy_q;
  assign pkt_cnt      = pkt_cnt_q;
  assign cmd_data     = cmd_data_q;

endmodule

// File: tb/tb_exfifo_pkt_ctrl.sv
module tb_exfifo_pkt_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] exfifo_if_d;
  logic        exfifo_if_rdempty;
  logic        exfifo_if_rd;
  logic [31:0] exfifo_of_d;
  logic        exfifo_of_wrfull;
  logic        exfifo_of_wr;
  logic        exfifo_rst;
  logic        cmd_rdy;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_ack;
  logic        rsp_we;
  logic [3:0]  rsp_addr;
  logic [31:0] rsp_wdata;
  logic        rsp_send;
  logic        busy;
  logic [15:0] pkt_cnt;

  exfifo_pkt_ctrl #(.PKT_WORDS(16), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .exfifo_if_d(exfifo_if_d), .exfifo_if_rdempty(exfifo_if_rdempty), .exfifo_if_rd(exfifo_if_rd),
    .exfifo_of_d(exfifo_of_d), .exfifo_of_wrfull(exfifo_of_wrfull), .exfifo_of_wr(exfifo_of_wr),
    .exfifo_rst(exfifo_rst), .cmd_rdy(cmd_rdy), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_ack(cmd_ack), .rsp_we(rsp_we), .rsp_addr(rsp_addr), .rsp_wdata(rsp_wdata),
    .rsp_send(rsp_send), .busy(busy), .pkt_cnt(pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Inbound FIFO model and outbound capture
  logic [31:0] in_q[$];
  logic [31:0] out_q[$];
  int cyc = 0;
  int rd_cnt, wr_cnt, first_rd, last_rd, first_wr, last_wr, rd_viol, wr_viol;
  bit gap_en = 1'b0;
  int stall_at = 0;
  int stall_left = 0;

  task automatic clear_stats();
    rd_cnt = 0; wr_cnt = 0; rd_viol = 0; wr_viol = 0;
    first_rd = -1; last_rd = -1; first_wr = -1; last_wr = -1;
    out_q.delete();
  endtask

  // One clock cycle: drive FIFO flags, sample strobes, advance past the edge
  task automatic step();
    logic rd_s, wr_s;
    logic [31:0] d_s;
    if (stall_left > 0 && out_q.size() == stall_at) begin
      exfifo_of_wrfull = 1'b1;
      stall_left--;
    end else begin
      exfifo_of_wrfull = 1'b0;
    end
    exfifo_if_rdempty = (in_q.size() == 0) || (gap_en && cyc[0]);
    exfifo_if_d = (in_q.size() != 0) ? in_q[0] : 32'h0;
    #1;
    rd_s = exfifo_if_rd;
    wr_s = exfifo_of_wr;
    d_s  = exfifo_of_d;
    if (rd_s && exfifo_if_rdempty) rd_viol++;
    if (wr_s && exfifo_of_wrfull) wr_viol++;
    if (rd_s) begin
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
      rd_cnt++;
      if (in_q.size() != 0) void'(in_q.pop_front());
    end
    if (wr_s) begin
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      wr_cnt++;
      out_q.push_back(d_s);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic push_packet(input logic [31:0] base);
    for (int i = 0; i < 16; i++) in_q.push_back(base + 32'(i));
  endtask

  task automatic wait_cmd_rdy(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (cmd_rdy) break;
      step();
    end
  endtask

  task automatic read_cmd(input logic [3:0] addr, output logic [31:0] data);
    cmd_addr = addr;
    step();
    data = cmd_data;
  endtask

  task automatic write_rsp(input logic [31:0] base);
    for (int i = 0; i < 16; i++) begin
      rsp_we = 1'b1; rsp_addr = 4'(i); rsp_wdata = base + 32'(i);
      step();
    end
    rsp_we = 1'b0;
  endtask

  task automatic pulse_ack();
    cmd_ack = 1'b1; step(); cmd_ack = 1'b0;
  endtask

  task automatic pulse_send();
    rsp_send = 1'b1; step(); rsp_send = 1'b0;
  endtask

  // Step through TX until idle; optionally hammer the response buffer meanwhile
  task automatic run_tx(input bit corrupt);
    for (int i = 0; i < 80; i++) begin
      if (corrupt) begin
        rsp_we = 1'b1; rsp_addr = 4'(i); rsp_wdata = 32'hDEAD_0000 + 32'(i);
      end
      step();
      if (!busy) break;
    end
    rsp_we = 1'b0;
  endtask

  task automatic full_packet(input logic [31:0] cbase, input logic [31:0] rbase);
    push_packet(cbase);
    clear_stats();
    wait_cmd_rdy(60);
    write_rsp(rbase);
    pulse_ack();
    out_q.delete();
    pulse_send();
    run_tx(1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL reset_cmd_rdy: got %0b expected 0", cmd_rdy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (pkt_cnt !== 16'h0) begin errors++; $display("FAIL reset_pkt_cnt: got %h expected 0000", pkt_cnt); end
    checks++; if (cmd_data !== 32'h0) begin errors++; $display("FAIL reset_cmd_data: got %h expected 0", cmd_data); end
    checks++; if ({exfifo_if_rd, exfifo_of_wr} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b expected 00", {exfifo_if_rd, exfifo_of_wr}); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_round_trip();
    int start, bad, send_cyc;
    logic [31:0] d;
    push_packet(32'h1000_0000);
    clear_stats();
    start = cyc;
    repeat (16) step();
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL rt_cmd_rdy_early: got %0b expected 0", cmd_rdy); end
    step();
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL rt_cmd_rdy_c17: got %0b expected 1", cmd_rdy); end
    checks++; if (rd_cnt != 16 || first_rd != start + 1 || last_rd != start + 16) begin
      errors++; $display("FAIL rt_pops: got cnt=%0d first=%0d last=%0d expected 16/%0d/%0d", rd_cnt, first_rd, last_rd, start + 1, start + 16);
    end
    read_cmd(4'd5, d);
    checks++; if (d !== 32'h1000_0005) begin errors++; $display("FAIL rt_cmd_data5: got %h expected 10000005", d); end
    read_cmd(4'd15, d);
    checks++; if (d !== 32'h1000_000F) begin errors++; $display("FAIL rt_cmd_data15: got %h expected 1000000f", d); end
    write_rsp(32'hA000_0000);
    pulse_ack();
    checks++; if (cmd_rdy !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rt_ack: got rdy=%0b busy=%0b expected 0/1", cmd_rdy, busy); end
    out_q.delete();
    send_cyc = cyc;
    pulse_send();
    run_tx(1'b0);
    checks++; if (first_wr != send_cyc + 1 || last_wr != send_cyc + 16) begin
      errors++; $display("FAIL rt_wr_timing: got first=%0d last=%0d expected %0d/%0d", first_wr, last_wr, send_cyc + 1, send_cyc + 16);
    end
    bad = (out_q.size() == 16) ? 0 : 1;
    for (int i = 0; i < out_q.size() && i < 16; i++) if (out_q[i] !== 32'hA000_0000 + 32'(i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rt_tx_words: got %0d bad of %0d words expected 0 bad of 16", bad, out_q.size()); end
    checks++; if (pkt_cnt !== 16'd1 || busy !== 1'b0) begin errors++; $display("FAIL rt_done: got cnt=%h busy=%0b expected 0001/0", pkt_cnt, busy); end
  endtask

  task automatic test_inbound_gaps();
    int bad;
    logic [31:0] d;
    push_packet(32'h2000_0000);
    clear_stats();
    gap_en = 1'b1;
    wait_cmd_rdy(80);
    gap_en = 1'b0;
    checks++; if (cmd_rdy !== 1'b1 || rd_cnt != 16) begin errors++; $display("FAIL gap_pops: got rdy=%0b pops=%0d expected 1/16", cmd_rdy, rd_cnt); end
    checks++; if (rd_viol != 0) begin errors++; $display("FAIL gap_rd_while_empty: got %0d expected 0", rd_viol); end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      read_cmd(4'(i), d);
      if (d !== 32'h2000_0000 + 32'(i)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL gap_order: got %0d bad words expected 0", bad); end
    write_rsp(32'hA100_0000);
    pulse_ack();
    out_q.delete();
    pulse_send();
    run_tx(1'b0);
    checks++; if (pkt_cnt !== 16'd2) begin errors++; $display("FAIL gap_pkt_cnt: got %h expected 0002", pkt_cnt); end
  endtask

  task automatic test_backpressure();
    int bad;
    push_packet(32'h4000_0000);
    clear_stats();
    wait_cmd_rdy(60);
    write_rsp(32'hB000_0000);
    pulse_ack();
    out_q.delete();
    stall_at = 4; stall_left = 3;
    pulse_send();
    run_tx(1'b0);
    checks++; if (wr_viol != 0) begin errors++; $display("FAIL bp_wr_while_full: got %0d expected 0", wr_viol); end
    checks++; if (last_wr - first_wr != 18) begin errors++; $display("FAIL bp_span: got %0d expected 18", last_wr - first_wr); end
    bad = (out_q.size() == 16) ? 0 : 1;
    for (int i = 0; i < out_q.size() && i < 16; i++) if (out_q[i] !== 32'hB000_0000 + 32'(i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_words: got %0d bad of %0d expected 0 bad of 16", bad, out_q.size()); end
    checks++; if (pkt_cnt !== 16'd3) begin errors++; $display("FAIL bp_pkt_cnt: got %h expected 0003", pkt_cnt); end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    push_packet(32'h2200_0000);
    clear_stats();
    for (int i = 0; i < 30; i++) begin
      if (rd_cnt == 7) break;
      step();
    end
    checks++; if (rd_cnt != 7) begin errors++; $display("FAIL fl_seven_pops: got %0d expected 7", rd_cnt); end
    exfifo_rst = 1'b1;
    step();
    exfifo_rst = 1'b0;
    in_q.delete();
    checks++; if (rd_cnt != 7) begin errors++; $display("FAIL fl_rd_during_flush: got %0d pops expected 7", rd_cnt); end
    checks++; if (busy !== 1'b0 || cmd_rdy !== 1'b0) begin errors++; $display("FAIL fl_idle: got busy=%0b rdy=%0b expected 0/0", busy, cmd_rdy); end
    repeat (3) step();
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL fl_rdy_stays_low: got %0b expected 0", cmd_rdy); end
    push_packet(32'h3000_0000);
    clear_stats();
    wait_cmd_rdy(60);
    checks++; if (cmd_rdy !== 1'b1 || rd_cnt != 16) begin errors++; $display("FAIL fl_reload: got rdy=%0b pops=%0d expected 1/16", cmd_rdy, rd_cnt); end
    read_cmd(4'd0, d);
    checks++; if (d !== 32'h3000_0000) begin errors++; $display("FAIL fl_idx0: got %h expected 30000000", d); end
    read_cmd(4'd15, d);
    checks++; if (d !== 32'h3000_000F) begin errors++; $display("FAIL fl_idx15: got %h expected 3000000f", d); end
    checks++; if (pkt_cnt !== 16'd3) begin errors++; $display("FAIL fl_pkt_cnt: got %h expected 0003", pkt_cnt); end
    write_rsp(32'hA300_0000);
    pulse_ack();
    pulse_send();
    run_tx(1'b0);
  endtask

  task automatic test_misuse();
    int bad;
    push_packet(32'h5000_0000);
    clear_stats();
    wait_cmd_rdy(60);
    write_rsp(32'hC000_0000);
    pulse_send();
    checks++; if (cmd_rdy !== 1'b1 || wr_cnt != 0) begin errors++; $display("FAIL mu_send_in_cmd_wait: got rdy=%0b wr=%0d expected 1/0", cmd_rdy, wr_cnt); end
    cmd_ack = 1'b1; rsp_send = 1'b1;
    step();
    cmd_ack = 1'b0; rsp_send = 1'b0;
    repeat (3) step();
    checks++; if (cmd_rdy !== 1'b0 || busy !== 1'b1 || wr_cnt != 0) begin
      errors++; $display("FAIL mu_ack_send_same: got rdy=%0b busy=%0b wr=%0d expected 0/1/0", cmd_rdy, busy, wr_cnt);
    end
    out_q.delete();
    pulse_send();
    run_tx(1'b1);
    bad = (out_q.size() == 16) ? 0 : 1;
    for (int i = 0; i < out_q.size() && i < 16; i++) if (out_q[i] !== 32'hC000_0000 + 32'(i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL mu_we_in_tx: got %0d bad of %0d expected 0 bad of 16", bad, out_q.size()); end
    checks++; if (pkt_cnt !== 16'd5) begin errors++; $display("FAIL mu_pkt_cnt: got %h expected 0005", pkt_cnt); end
  endtask

  task automatic test_wrap_and_reset();
    force dut.pkt_cnt_q = 16'hFFFF;
    step();
    release dut.pkt_cnt_q;
    step();
    checks++; if (pkt_cnt !== 16'hFFFF) begin errors++; $display("FAIL wr_preload: got %h expected ffff", pkt_cnt); end
    full_packet(32'h6000_0000, 32'hD000_0000);
    checks++; if (pkt_cnt !== 16'h0000) begin errors++; $display("FAIL wr_wrap: got %h expected 0000", pkt_cnt); end
    full_packet(32'h6100_0000, 32'hD100_0000);
    checks++; if (pkt_cnt !== 16'h0001) begin errors++; $display("FAIL wr_after_wrap: got %h expected 0001", pkt_cnt); end
    cmd_addr = 4'd3;
    push_packet(32'h6200_0000);
    clear_stats();
    wait_cmd_rdy(60);
    write_rsp(32'hD200_0000);
    pulse_ack();
    pulse_send();
    repeat (5) step();
    checks++; if (busy !== 1'b1 || wr_cnt != 5) begin errors++; $display("FAIL rst_mid_tx_setup: got busy=%0b wr=%0d expected 1/5", busy, wr_cnt); end
    reset = 1'b1;
    step();
    checks++; if (busy !== 1'b0 || cmd_rdy !== 1'b0 || pkt_cnt !== 16'h0 || cmd_data !== 32'h0 || exfifo_of_wr !== 1'b0 || exfifo_if_rd !== 1'b0) begin
      errors++; $display("FAIL rst_mid_tx: got busy=%0b rdy=%0b cnt=%h data=%h wr=%0b rd=%0b expected all 0",
                         busy, cmd_rdy, pkt_cnt, cmd_data, exfifo_of_wr, exfifo_if_rd);
    end
    reset = 1'b0;
    step();
    checks++; if (busy !== 1'b0 || exfifo_of_wr !== 1'b0) begin errors++; $display("FAIL rst_stays_idle: got busy=%0b wr=%0b expected 0/0", busy, exfifo_of_wr); end
  endtask

  initial begin
    reset = 1'b1;
    exfifo_if_d = 32'h0;
    exfifo_if_rdempty = 1'b1;
    exfifo_of_wrfull = 1'b0;
    exfifo_rst = 1'b0;
    cmd_addr = 4'd0;
    cmd_ack = 1'b0;
    rsp_we = 1'b0;
    rsp_addr = 4'd0;
    rsp_wdata = 32'h0;
    rsp_send = 1'b0;
    clear_stats();
    @(negedge clk);
    test_reset();
    test_round_trip();
    test_inbound_gaps();
    test_backpressure();
    test_flush();
    test_misuse();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
